// File: rtl/apb2axi_cpl_status_table.sv
// ---------------------------------------------------------------------------
// apb2axi_cpl_status_table
//
// Purpose:
//   Drains the completion FIFO (ACLK domain) and keeps the most recent
//   completion seen for every tag. The APB-side register file uses it to
//   see which tags have completed (pending / irq), to read back a tag's
//   completion with its overflow flag, and to clear a tag once handled.
//
// Optional feature macro: APB2AXI_CPL_STATS_EN
//   Defined   -> saturating read / write / error completion counters.
//   Undefined -> no counter flops, stat_* outputs tied to zero.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   cpl_pop_valid/data  completion entry offered by the FIFO
//                       {is_write, tag, resp[1:0], error, num_beats[7:0]}
//   cpl_pop_ready       registered, high from the first cycle after reset
//   rd_req, rd_tag      status read request
//   rd_rsp_valid/data   one-cycle response {ovf, valid, entry}, pre-update state
//   clr_valid, clr_tag  clear valid/ovf of one tag (entry data kept)
//   pending, irq        registered valid bitmap and its OR
//   stat_rd_cnt         accepted read completions
//   stat_wr_cnt         accepted write completions
//   stat_err_cnt        accepted completions with error=1
// ---------------------------------------------------------------------------
module apb2axi_cpl_status_table #(
    parameter int TAG_W        = 4,
    parameter int COMPLETION_W = 16,
    parameter int CNT_W        = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cpl_pop_valid,
    input  logic [COMPLETION_W-1:0]   cpl_pop_data,
    output logic                      cpl_pop_ready,
    input  logic                      rd_req,
    input  logic [TAG_W-1:0]          rd_tag,
    output logic                      rd_rsp_valid,
    output logic [COMPLETION_W+1:0]   rd_rsp_data,
    input  logic                      clr_valid,
    input  logic [TAG_W-1:0]          clr_tag,
    output logic [(2**TAG_W)-1:0]     pending,
    output logic                      irq,
    output logic [CNT_W-1:0]          stat_rd_cnt,
    output logic [CNT_W-1:0]          stat_wr_cnt,
    output logic [CNT_W-1:0]          stat_err_cnt
);

    localparam int N_TAG   = 2**TAG_W;
    localparam int TAG_LSB = 11;

    if (COMPLETION_W != 12 + TAG_W) begin : g_bad_width
        $error("COMPLETION_W must equal 12 + TAG_W");
    end

    // Field extraction from the incoming completion entry.
    logic [TAG_W-1:0] cpl_tag;
    logic             cpl_is_write;
    logic             cpl_error;
    logic             accept;

    assign cpl_tag      = cpl_pop_data[TAG_LSB +: TAG_W];
    assign cpl_is_write = cpl_pop_data[COMPLETION_W-1];
    assign cpl_error    = cpl_pop_data[8];

    // State
    logic                    ready_q;
    logic [N_TAG-1:0]        valid_q, valid_d;
    logic [N_TAG-1:0]        ovf_q, ovf_d;
    logic [COMPLETION_W-1:0] entry_q [N_TAG];
    logic [COMPLETION_W-1:0] entry_d [N_TAG];
    logic                    rd_rsp_valid_q, rd_rsp_valid_d;
    logic [COMPLETION_W+1:0] rd_rsp_data_q, rd_rsp_data_d;
    logic [N_TAG-1:0]        pending_q, pending_d;
    logic                    irq_q, irq_d;

    assign accept = cpl_pop_valid && ready_q;

    // Per-tag next state. On a same-tag accept+clear the clear consumed the
    // old entry, so the new one arrives without an overflow.
    always_comb begin
        for (int i = 0; i < N_TAG; i++) begin
            valid_d[i] = valid_q[i];
            ovf_d[i]   = ovf_q[i];
            entry_d[i] = entry_q[i];
            if (clr_valid && (clr_tag == TAG_W'(i))) begin
                valid_d[i] = 1'b0;
                ovf_d[i]   = 1'b0;
            end
            if (accept && (cpl_tag == TAG_W'(i))) begin
                valid_d[i] = 1'b1;
                entry_d[i] = cpl_pop_data;
                if (!(clr_valid && (clr_tag == TAG_W'(i)))) begin
                    ovf_d[i] = ovf_q[i] | valid_q[i];
                end
            end
        end
    end

    // Readout samples the current (pre-update) state; data holds between reads.
    always_comb begin
        rd_rsp_valid_d = rd_req;
        rd_rsp_data_d  = rd_rsp_data_q;
        if (rd_req) begin
            rd_rsp_data_d = {ovf_q[rd_tag], valid_q[rd_tag], entry_q[rd_tag]};
        end
    end

    // pending/irq follow the new valid vector so they appear the cycle after accept.
    always_comb begin
        pending_d = valid_d;
        irq_d     = |valid_d;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_q        <= 1'b0;
            valid_q        <= '0;
            ovf_q          <= '0;
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_data_q  <= '0;
            pending_q      <= '0;
            irq_q          <= 1'b0;
            for (int i = 0; i < N_TAG; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            ready_q        <= 1'b1;
            valid_q        <= valid_d;
            ovf_q          <= ovf_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
            pending_q      <= pending_d;
            irq_q          <= irq_d;
            for (int i = 0; i < N_TAG; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign cpl_pop_ready = ready_q;
    assign rd_rsp_valid  = rd_rsp_valid_q;
    assign rd_rsp_data   = rd_rsp_data_q;
    assign pending       = pending_q;
    assign irq           = irq_q;

`ifdef APB2AXI_CPL_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating counters: stop at all-ones instead of wrapping.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (!cpl_is_write && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
            if (cpl_is_write && (wr_cnt_q != '1))  wr_cnt_d = wr_cnt_q + 1'b1;
            if (cpl_error && (err_cnt_q != '1))    err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`else
    assign stat_rd_cnt  = '0;
    assign stat_wr_cnt  = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_apb2axi_cpl_status_table.sv
module tb_apb2axi_cpl_status_table;

    logic        aclk;
    logic        areset;
    logic        cpl_pop_valid;
    logic [15:0] cpl_pop_data;
    logic        cpl_pop_ready;
    logic        rd_req;
    logic [3:0]  rd_tag;
    logic        rd_rsp_valid;
    logic [17:0] rd_rsp_data;
    logic        clr_valid;
    logic [3:0]  clr_tag;
    logic [15:0] pending;
    logic        irq;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_err_cnt;

    int n_cmp;
    int n_bad;

    // Expected counter values; stay zero when the statistics feature is absent.
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic [15:0] exp_err;

    apb2axi_cpl_status_table dut (
        .aclk          (aclk),
        .areset        (areset),
        .cpl_pop_valid (cpl_pop_valid),
        .cpl_pop_data  (cpl_pop_data),
        .cpl_pop_ready (cpl_pop_ready),
        .rd_req        (rd_req),
        .rd_tag        (rd_tag),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .clr_valid     (clr_valid),
        .clr_tag       (clr_tag),
        .pending       (pending),
        .irq           (irq),
        .stat_rd_cnt   (stat_rd_cnt),
        .stat_wr_cnt   (stat_wr_cnt),
        .stat_err_cnt  (stat_err_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [15:0] mk(input logic w, input logic [3:0] t,
                                       input logic [1:0] r, input logic e,
                                       input logic [7:0] nb);
        return {w, t, r, e, nb};
    endfunction

    // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
    task automatic drive(input logic pv, input logic [15:0] pd,
                         input logic rq, input logic [3:0] rt,
                         input logic cv, input logic [3:0] ct);
        cpl_pop_valid = pv;
        cpl_pop_data  = pd;
        rd_req        = rq;
        rd_tag        = rt;
        clr_valid     = cv;
        clr_tag       = ct;
        @(posedge aclk);
        #1;
        cpl_pop_valid = 1'b0;
        cpl_pop_data  = 16'h0;
        rd_req        = 1'b0;
        clr_valid     = 1'b0;
`ifdef APB2AXI_CPL_STATS_EN
        if (pv) begin
            if (!pd[15] && exp_rd != 16'hFFFF)  exp_rd++;
            if (pd[15] && exp_wr != 16'hFFFF)   exp_wr++;
            if (pd[8] && exp_err != 16'hFFFF)   exp_err++;
        end
`endif
    endtask

    task automatic push(input logic [15:0] pd);
        drive(1'b1, pd, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] t, input logic [17:0] exp);
        drive(1'b0, 16'h0, 1'b1, t, 1'b0, 4'd0);
        check({tag, "_vld"}, {31'd0, rd_rsp_valid}, 32'd1);
        check({tag, "_dat"}, {14'd0, rd_rsp_data}, {14'd0, exp});
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_rdcnt"},  {16'd0, stat_rd_cnt},  {16'd0, exp_rd});
        check({tag, "_wrcnt"},  {16'd0, stat_wr_cnt},  {16'd0, exp_wr});
        check({tag, "_errcnt"}, {16'd0, stat_err_cnt}, {16'd0, exp_err});
    endtask

    logic [15:0] d_a, d_b;

    initial begin
        n_cmp = 0; n_bad = 0;
        exp_rd = 16'd0; exp_wr = 16'd0; exp_err = 16'd0;
        areset = 1'b1;
        cpl_pop_valid = 1'b0; cpl_pop_data = 16'h0;
        rd_req = 1'b0; rd_tag = 4'd0; clr_valid = 1'b0; clr_tag = 4'd0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ready",   {31'd0, cpl_pop_ready}, 32'd0);
        check("rst_pending", {16'd0, pending}, 32'd0);
        check("rst_irq",     {31'd0, irq}, 32'd0);
        check("rst_rsp_vld", {31'd0, rd_rsp_valid}, 32'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("rel_ready", {31'd0, cpl_pop_ready}, 32'd1);
        check_counters("rel");

        // Single read completion on tag 3
        push(mk(1'b0, 4'd3, 2'b00, 1'b0, 8'd4));
        check("t1_pending", {16'd0, pending}, 32'h0008);
        check("t1_irq",     {31'd0, irq}, 32'd1);
        read_chk("t1_rd3", 4'd3, {2'b01, 16'h1804});
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
        check("t1_rsp_pulse", {31'd0, rd_rsp_valid}, 32'd0);
        check_counters("t1");

        // Overflow on tag 5: second write completion overwrites the first
        d_a = mk(1'b1, 4'd5, 2'b10, 1'b1, 8'd1);
        d_b = mk(1'b1, 4'd5, 2'b00, 1'b0, 8'd2);
        push(d_a);
        push(d_b);
        read_chk("t2_rd5", 4'd5, {2'b11, 16'hA802});
        check_counters("t2");

        // Back-to-back reads
        drive(1'b0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0);
        check("bb_rsp0", {14'd0, rd_rsp_data}, {14'd0, 2'b01, 16'h1804});
        drive(1'b0, 16'h0, 1'b1, 4'd5, 1'b0, 4'd0);
        check("bb_vld1", {31'd0, rd_rsp_valid}, 32'd1);
        check("bb_rsp1", {14'd0, rd_rsp_data}, {14'd0, 2'b11, 16'hA802});

        // Same-tag accept + clear on tag 7: accept wins, ovf forced low
        push(mk(1'b0, 4'd7, 2'b00, 1'b0, 8'd1));
        drive(1'b1, mk(1'b0, 4'd7, 2'b01, 1'b0, 8'd9), 1'b0, 4'd0, 1'b1, 4'd7);
        read_chk("t3_rd7", 4'd7, {2'b01, 16'h3A09});

        // Different-tag accept (2) + clear (4)
        push(mk(1'b0, 4'd4, 2'b00, 1'b0, 8'd3));
        drive(1'b1, mk(1'b0, 4'd2, 2'b00, 1'b0, 8'd5), 1'b0, 4'd0, 1'b1, 4'd4);
        check("t3_pending", {16'd0, pending}, 32'h00AC);

        // Clear-only keeps entry data, drops valid and ovf
        drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd5);
        check("clr5_pending", {16'd0, pending}, 32'h008C);
        read_chk("clr5_rd", 4'd5, {2'b00, 16'hA802});

        // Read of tag 9 in the same cycle as its first accept shows old state
        drive(1'b1, mk(1'b1, 4'd9, 2'b11, 1'b1, 8'd7), 1'b1, 4'd9, 1'b0, 4'd0);
        check("t4_same_vld", {31'd0, rd_rsp_valid}, 32'd1);
        check("t4_same_dat", {14'd0, rd_rsp_data}, 32'd0);
        read_chk("t4_next", 4'd9, {2'b01, 16'hCF07});
        check_counters("t4");

        // Counter saturation
`ifdef APB2AXI_CPL_STATS_EN
        while (exp_err != 16'hFFFE) push(mk(1'b0, 4'd0, 2'b00, 1'b1, 8'd0));
        check("sat_pre", {16'd0, stat_err_cnt}, 32'h0000FFFE);
        repeat (3) push(mk(1'b1, 4'd1, 2'b10, 1'b1, 8'd0));
        check("sat_err", {16'd0, stat_err_cnt}, 32'h0000FFFF);
`else
        repeat (3) push(mk(1'b1, 4'd1, 2'b10, 1'b1, 8'd0));
`endif
        check_counters("sat");

        // Fill every tag, then reset with a read response in flight
        for (int i = 0; i < 16; i++) push(mk(1'b0, 4'(i), 2'b00, 1'b0, 8'(i)));
        check("full_pending", {16'd0, pending}, 32'h0000FFFF);
        rd_req = 1'b1; rd_tag = 4'd3;
        @(posedge aclk);
        #2;
        check("pre_rst_vld", {31'd0, rd_rsp_valid}, 32'd1);
        areset = 1'b1;
        #1;
        check("arst_pending", {16'd0, pending}, 32'd0);
        check("arst_irq",     {31'd0, irq}, 32'd0);
        check("arst_rsp_vld", {31'd0, rd_rsp_valid}, 32'd0);
        check("arst_ready",   {31'd0, cpl_pop_ready}, 32'd0);
        rd_req = 1'b0;
        exp_rd = 16'd0; exp_wr = 16'd0; exp_err = 16'd0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("arst_ready_hold", {31'd0, cpl_pop_ready}, 32'd0);
        @(posedge aclk);
        #1;
        check("post_ready", {31'd0, cpl_pop_ready}, 32'd1);
        check_counters("post");
        read_chk("post_rd3", 4'd3, 18'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
